flash_page_burst_splitter: RTL and testbench
============================================

// Module: flash_page_burst_splitter
// PURPOSE
//  Sits between flash_burst_master and the flash controller's AVMM slave. Takes AVMM write/read
//  bursts of up to 64 words at any word-aligned address. Re-issues each one as sub-bursts that
//  never cross a PAGE_BYTES boundary and never exceed MAX_BURST words. The burst master steps its
//  address by 256 B from a start address that need not be page-aligned, so page program
//  correctness depends on this split.
// PARAMETERS
//  FLASH_ADDR_WIDTH  28   byte address width, both sides
//  PAGE_BYTES        256  flash program page size in bytes; power of 2, >=8
//  MAX_BURST         64   maximum downstream burstcount in words; <= 2**BURST_WIDTH-1
//  BURST_WIDTH       7    burstcount width, both sides
// PORTS
//  clk            in   1    sole clock
//  reset          in   1    synchronous, active-high
//  avmm_slv_addr  in   FAW  upstream byte address; bits [1:0] ignored
//  avmm_slv_write / avmm_slv_read  in  1  upstream write / read request
//  avmm_slv_burstcnt  in  BW  upstream burst length in words; 0 = illegal
//  avmm_slv_wrdata / avmm_slv_rddata  in / out  32  upstream write / read data
//  avmm_slv_rddvld / avmm_slv_waitreq  out  1  upstream read valid / wait request
//  avmm_mstr_addr  out  FAW  downstream address, bits [1:0] always 0
//  avmm_mstr_write / avmm_mstr_read  out  1  downstream write / read request
//  avmm_mstr_burstcnt  out  BW  downstream sub-burst length
//  avmm_mstr_wrdata / avmm_mstr_rddata  out / in  32  downstream write / read data
//  avmm_mstr_rddvld / avmm_mstr_waitreq  in  1  downstream read valid / wait request
//  err_zero_burst  out  1    sticky; set on a burstcnt==0 command; cleared only by reset
// BEHAVIOUR
//  Reset (sync): state IDLE; slv_waitreq=1; mstr_write=mstr_read=0; slv_rddvld=0; err=0; regs 0.
//  Sub-length calculation:
//   - len = min(rem, (PAGE_BYTES - addr_r[log2(PAGE_BYTES)-1:0]) >> 2, MAX_BURST).
//   - len is combinational from addr_r/rem and drives mstr_burstcnt. mstr_addr = {addr_r[FAW-1:2], 2'b00}.
//  FSM:
//  IDLE
//   - slv_waitreq=1.
//   - On slv_write or slv_read: addr_r<=slv_addr & ~3; rem<=slv_burstcnt; beat<=0.
//   - burstcnt==0: set err, go ZERO_ACK (slv_waitreq=0 for 1 cycle), then IDLE. Nothing goes downstream.
//   - Otherwise: write -> WR_DATA, read -> RD_ACK. Write has priority if both are set.
//  WR_DATA
//   - Pass-through: mstr_write=slv_write, mstr_wrdata=slv_wrdata, slv_waitreq=mstr_waitreq.
//   - A beat is accepted when slv_write & !mstr_waitreq; beat++ on each accepted beat.
//   - When beat reaches len-1 on an accepted beat: addr_r+=len*4, rem-=len, beat<=0. If the new rem==0, go IDLE.
//   - New addr/burstcnt are presented with the next beat (AVMM first-beat semantics).
//   - Upstream idle cycles (slv_write=0) are legal; state is held.
//  RD_ACK: slv_waitreq=0 for exactly 1 cycle (accepts upstream read); -> RD_CMD.
//  RD_CMD
//   - mstr_read=1, held until !mstr_waitreq. On acceptance: cnt<=len; go RD_DATA.
//  RD_DATA
//   - slv_rddata=mstr_rddata and slv_rddvld=mstr_rddvld, combinational, zero latency.
//   - cnt-- per rddvld. On the last beat: addr_r+=len*4, rem-=len. rem==0 -> IDLE, else -> RD_CMD.
//   - One downstream read outstanding at a time.
//  slv_rddvld is forced 0 outside RD_DATA; stray mstr_rddvld there is dropped.
//  New upstream commands are not accepted until the current one fully completes.
//  Arithmetic: addr_r wraps modulo 2**FAW, no error. rem/len/cnt are BURST_WIDTH bits, unsigned.
//  Reset mid-operation: immediate IDLE, all requests drop, downstream data still in flight is ignored.
//  Latency: command seen -> first mstr_write/mstr_read = 1 clk (capture cycle).
// STRUCTURE
//  Package flash_pkg: PAGE_BYTES default, fsm state enum (IDLE, ZERO_ACK, WR_DATA, RD_ACK, RD_CMD, RD_DATA),
//  and function page_sub_len(addr, rem) shared with the bench scoreboard.
//  Single module; sub-length math stays an inline function, no sub-module.
// TESTING
//  1 Write addr=0x100 cnt=64, waitreq=0 -> one mstr burst: addr 0x100, cnt 64, 64 data beats in order.
//  2 Write addr=0x1F0 cnt=64 -> mstr bursts (0x1F0,4) then (0x200,60); data order preserved.
//  3 Read addr=0x3FC cnt=10 -> mstr reads (0x3FC,1) then (0x400,9); exactly 10 slv_rddvld; data equals the model.
//  4 Random mstr_waitreq (50%) during write cnt=33 @0xE0 -> slv_waitreq mirrors it; no beat lost or duplicated.
//  5 Command with burstcnt=0 -> err_zero_burst=1; no mstr_write/read; slv_waitreq low for 1 clk.
//  6 Reset asserted mid-RD_DATA, then a new write issued -> outputs at reset values in the next clk;
//    stale rddvld not forwarded; the new write completes correctly.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared definitions for the flash page burst splitter.
//  - Default geometry (address width, page size, max burst, burstcount width).
//  - FSM state encoding.
//  - page_sub_len(): sub-burst length at the default geometry.
package flash_pkg;

  localparam int unsigned DEF_FLASH_ADDR_WIDTH = 28;
  localparam int unsigned DEF_PAGE_BYTES       = 256;
  localparam int unsigned DEF_MAX_BURST        = 64;
  localparam int unsigned DEF_BURST_WIDTH      = 7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ZERO_ACK = 3'd1,
    WR_DATA  = 3'd2,
    RD_ACK   = 3'd3,
    RD_CMD   = 3'd4,
    RD_DATA  = 3'd5
  } fsm_state_t;

  // Words left before the next page boundary, clipped to rem and the max burst.
  function automatic logic [DEF_BURST_WIDTH-1:0] page_sub_len(
    input logic [DEF_FLASH_ADDR_WIDTH-1:0] addr,
    input logic [DEF_BURST_WIDTH-1:0]      rem
  );
    int unsigned off;
    int unsigned room;
    int unsigned len;
    off  = 32'(addr % DEF_FLASH_ADDR_WIDTH'(DEF_PAGE_BYTES)) & ~32'd3;
    room = (DEF_PAGE_BYTES - off) >> 2;
    len  = 32'(rem);
    if (room < len) len = room;
    if (DEF_MAX_BURST < len) len = DEF_MAX_BURST;
    return DEF_BURST_WIDTH'(len);
  endfunction

endpackage

// File: rtl/flash_page_burst_splitter.sv
// Re-issues upstream AVMM bursts as downstream sub-bursts that never cross a
// flash page boundary and never exceed MAX_BURST words.
// Ports:
//  clk, reset                  clock, synchronous active-high reset
//  avmm_slv_*                  upstream AVMM slave (from the burst master)
//  avmm_mstr_*                 downstream AVMM master (to the flash controller)
//  err_zero_burst              sticky flag, set by a burstcnt==0 command
module flash_page_burst_splitter
  import flash_pkg::*;
#(
  parameter int unsigned FLASH_ADDR_WIDTH = DEF_FLASH_ADDR_WIDTH,
  parameter int unsigned PAGE_BYTES       = DEF_PAGE_BYTES,
  parameter int unsigned MAX_BURST        = DEF_MAX_BURST,
  parameter int unsigned BURST_WIDTH      = DEF_BURST_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [FLASH_ADDR_WIDTH-1:0] avmm_slv_addr,
  input  logic                        avmm_slv_write,
  input  logic                        avmm_slv_read,
  input  logic [BURST_WIDTH-1:0]      avmm_slv_burstcnt,
  input  logic [31:0]                 avmm_slv_wrdata,
  output logic [31:0]                 avmm_slv_rddata,
  output logic                        avmm_slv_rddvld,
  output logic                        avmm_slv_waitreq,
  output logic [FLASH_ADDR_WIDTH-1:0] avmm_mstr_addr,
  output logic                        avmm_mstr_write,
  output logic                        avmm_mstr_read,
  output logic [BURST_WIDTH-1:0]      avmm_mstr_burstcnt,
  output logic [31:0]                 avmm_mstr_wrdata,
  input  logic [31:0]                 avmm_mstr_rddata,
  input  logic                        avmm_mstr_rddvld,
  input  logic                        avmm_mstr_waitreq,
  output logic                        err_zero_burst
);

  localparam int unsigned FAW = FLASH_ADDR_WIDTH;
  localparam int unsigned BW  = BURST_WIDTH;

  fsm_state_t     r_state, w_state_nxt;
  logic [FAW-1:0] r_addr,  w_addr_nxt;
  logic [BW-1:0]  r_rem,   w_rem_nxt;
  logic [BW-1:0]  r_beat,  w_beat_nxt;
  logic [BW-1:0]  r_cnt,   w_cnt_nxt;
  logic           r_err,   w_err_nxt;

  logic [BW-1:0]  w_len;
  logic [FAW-1:0] w_addr_adv;
  logic [BW-1:0]  w_rem_adv;

  // Sub-burst length: min(rem, words to page end, MAX_BURST).
  function automatic logic [BW-1:0] sub_len(input logic [FAW-1:0] addr,
                                            input logic [BW-1:0]  rem);
    int unsigned off;
    int unsigned room;
    int unsigned len;
    off  = 32'(addr % FAW'(PAGE_BYTES)) & ~32'd3;
    room = (PAGE_BYTES - off) >> 2;
    len  = 32'(rem);
    if (room < len) len = room;
    if (MAX_BURST < len) len = MAX_BURST;
    return BW'(len);
  endfunction

  assign w_len      = sub_len(r_addr, r_rem);
  assign w_addr_adv = r_addr + FAW'({w_len, 2'b00});
  assign w_rem_adv  = r_rem - w_len;

  // Address low bits are cleared at capture and only ever advance by whole words.
  assign avmm_mstr_addr     = r_addr;
  assign avmm_mstr_burstcnt = w_len;
  assign avmm_mstr_wrdata   = avmm_slv_wrdata;
  assign avmm_slv_rddata    = avmm_mstr_rddata;
  assign err_zero_burst     = r_err;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
      r_beat  <= w_beat_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_rem_nxt        = r_rem;
    w_beat_nxt       = r_beat;
    w_cnt_nxt        = r_cnt;
    w_err_nxt        = r_err;
    avmm_slv_waitreq = 1'b1;
    avmm_slv_rddvld  = 1'b0;
    avmm_mstr_write  = 1'b0;
    avmm_mstr_read   = 1'b0;

    case (r_state)
      IDLE: begin
        if (avmm_slv_write || avmm_slv_read) begin
          w_addr_nxt = avmm_slv_addr & ~FAW'(3);
          w_rem_nxt  = avmm_slv_burstcnt;
          w_beat_nxt = '0;
          if (avmm_slv_burstcnt == '0) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ZERO_ACK;
          end else if (avmm_slv_write) begin
            w_state_nxt = WR_DATA;
          end else begin
            w_state_nxt = RD_ACK;
          end
        end
      end

      ZERO_ACK: begin
        avmm_slv_waitreq = 1'b0;
        w_state_nxt      = IDLE;
      end

      WR_DATA: begin
        avmm_mstr_write  = avmm_slv_write;
        avmm_slv_waitreq = avmm_mstr_waitreq;
        if (avmm_slv_write && !avmm_mstr_waitreq) begin
          // Closing a sub-burst: the next beat carries the new address/burstcount.
          if (r_beat == w_len - BW'(1)) begin
            w_beat_nxt = '0;
            w_addr_nxt = w_addr_adv;
            w_rem_nxt  = w_rem_adv;
            if (w_rem_adv == '0) w_state_nxt = IDLE;
          end else begin
            w_beat_nxt = r_beat + BW'(1);
          end
        end
      end

      RD_ACK: begin
        avmm_slv_waitreq = 1'b0;
        w_state_nxt      = RD_CMD;
      end

      RD_CMD: begin
        avmm_mstr_read = 1'b1;
        if (!avmm_mstr_waitreq) begin
          w_cnt_nxt   = w_len;
          w_state_nxt = RD_DATA;
        end
      end

      RD_DATA: begin
        avmm_slv_rddvld = avmm_mstr_rddvld;
        if (avmm_mstr_rddvld) begin
          w_cnt_nxt = r_cnt - BW'(1);
          if (r_cnt == BW'(1)) begin
            w_addr_nxt  = w_addr_adv;
            w_rem_nxt   = w_rem_adv;
            w_state_nxt = (w_rem_adv == '0) ? IDLE : RD_CMD;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flash_page_burst_splitter.sv
// Scoreboard bench for flash_page_burst_splitter: stimulus pushes hand-computed
// sub-burst commands and data into queues, monitors pop and compare.
module tb_flash_page_burst_splitter;
  import flash_pkg::*;

  localparam int unsigned FAW = 28;
  localparam int unsigned BW  = 7;

  logic           clk = 1'b0;
  logic           reset;
  logic [FAW-1:0] avmm_slv_addr;
  logic           avmm_slv_write;
  logic           avmm_slv_read;
  logic [BW-1:0]  avmm_slv_burstcnt;
  logic [31:0]    avmm_slv_wrdata;
  logic [31:0]    avmm_slv_rddata;
  logic           avmm_slv_rddvld;
  logic           avmm_slv_waitreq;
  logic [FAW-1:0] avmm_mstr_addr;
  logic           avmm_mstr_write;
  logic           avmm_mstr_read;
  logic [BW-1:0]  avmm_mstr_burstcnt;
  logic [31:0]    avmm_mstr_wrdata;
  logic [31:0]    avmm_mstr_rddata;
  logic           avmm_mstr_rddvld;
  logic           avmm_mstr_waitreq;
  logic           err_zero_burst;

  always #5 clk = ~clk;

  flash_page_burst_splitter dut (
    .clk               (clk),
    .reset             (reset),
    .avmm_slv_addr     (avmm_slv_addr),
    .avmm_slv_write    (avmm_slv_write),
    .avmm_slv_read     (avmm_slv_read),
    .avmm_slv_burstcnt (avmm_slv_burstcnt),
    .avmm_slv_wrdata   (avmm_slv_wrdata),
    .avmm_slv_rddata   (avmm_slv_rddata),
    .avmm_slv_rddvld   (avmm_slv_rddvld),
    .avmm_slv_waitreq  (avmm_slv_waitreq),
    .avmm_mstr_addr    (avmm_mstr_addr),
    .avmm_mstr_write   (avmm_mstr_write),
    .avmm_mstr_read    (avmm_mstr_read),
    .avmm_mstr_burstcnt(avmm_mstr_burstcnt),
    .avmm_mstr_wrdata  (avmm_mstr_wrdata),
    .avmm_mstr_rddata  (avmm_mstr_rddata),
    .avmm_mstr_rddvld  (avmm_mstr_rddvld),
    .avmm_mstr_waitreq (avmm_mstr_waitreq),
    .err_zero_burst    (err_zero_burst)
  );

  typedef struct packed {
    logic           wr;
    logic [FAW-1:0] addr;
    logic [BW-1:0]  cnt;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          rd_seen  = 0;
  bit          rand_wait = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  function automatic cmd_t mk_cmd(input logic wr, input logic [FAW-1:0] addr, input int cnt);
    cmd_t c;
    c.wr   = wr;
    c.addr = addr;
    c.cnt  = BW'(cnt);
    return c;
  endfunction

  // Downstream flash-controller model: checks commands and write beats,
  // returns read data {4'hD, word address} one beat per cycle.
  initial begin : slave
    int             wr_left;
    int             rd_left;
    logic [FAW-1:0] rd_addr;
    cmd_t           c;
    wr_left = 0;
    rd_left = 0;
    rd_addr = '0;
    avmm_mstr_waitreq = 1'b0;
    avmm_mstr_rddvld  = 1'b0;
    avmm_mstr_rddata  = '0;
    forever begin
      @(negedge clk);
      if (avmm_mstr_write && !avmm_mstr_waitreq) begin
        if (wr_left <= 0) begin
          if (exp_cmd.size() == 0) begin
            flag("mstr_wr_cmd unexpected write burst");
          end else begin
            c = exp_cmd.pop_front();
            check("mstr_wr_cmd_dir", 32'(avmm_mstr_read), 32'(!c.wr));
            check("mstr_wr_cmd_addr", 32'(avmm_mstr_addr), 32'(c.addr));
            check("mstr_wr_cmd_cnt", 32'(avmm_mstr_burstcnt), 32'(c.cnt));
          end
          wr_left = int'(avmm_mstr_burstcnt);
        end
        if (exp_wr.size() == 0) flag("mstr_wrdata unexpected beat");
        else check("mstr_wrdata", avmm_mstr_wrdata, exp_wr.pop_front());
        wr_left--;
      end
      if (avmm_mstr_read && !avmm_mstr_waitreq) begin
        if (exp_cmd.size() == 0) begin
          flag("mstr_rd_cmd unexpected read");
        end else begin
          c = exp_cmd.pop_front();
          check("mstr_rd_cmd_dir", 32'(avmm_mstr_write), 32'(c.wr));
          check("mstr_rd_cmd_addr", 32'(avmm_mstr_addr), 32'(c.addr));
          check("mstr_rd_cmd_cnt", 32'(avmm_mstr_burstcnt), 32'(c.cnt));
        end
        rd_left = int'(avmm_mstr_burstcnt);
        rd_addr = avmm_mstr_addr;
      end
      @(posedge clk);
      #1;
      avmm_mstr_waitreq = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rd_left > 0) begin
        avmm_mstr_rddvld = 1'b1;
        avmm_mstr_rddata = {4'hD, rd_addr};
        rd_addr += FAW'(4);
        rd_left--;
      end else begin
        avmm_mstr_rddvld = 1'b0;
        avmm_mstr_rddata = '0;
      end
    end
  end

  // Upstream read-data monitor.
  always @(negedge clk) begin
    if (avmm_slv_rddvld) begin
      rd_seen++;
      if (exp_rd.size() == 0) flag("slv_rddvld unexpected beat");
      else check("slv_rddata", avmm_slv_rddata, exp_rd.pop_front());
    end
  end

  task automatic do_write(input logic [FAW-1:0] addr, input int cnt,
                          input logic [7:0] tag, input string name);
    int i;
    int guard;
    for (int k = 0; k < cnt; k++) exp_wr.push_back({tag, 24'(k)});
    @(posedge clk); #1;
    avmm_slv_addr     = addr;
    avmm_slv_burstcnt = BW'(cnt);
    avmm_slv_write    = 1'b1;
    avmm_slv_wrdata   = {tag, 24'(0)};
    @(negedge clk);
    check({name, "_capture_waitreq"}, 32'(avmm_slv_waitreq), 32'd1);
    check({name, "_capture_mstr_write"}, 32'(avmm_mstr_write), 32'd0);
    i = 0;
    guard = 0;
    while (i < cnt && guard < 2000) begin
      @(posedge clk); #1;
      avmm_slv_wrdata = {tag, 24'(i)};
      @(negedge clk);
      if (guard == 0) check({name, "_first_mstr_write"}, 32'(avmm_mstr_write), 32'd1);
      check({name, "_waitreq_mirror"}, 32'(avmm_slv_waitreq), 32'(avmm_mstr_waitreq));
      if (!avmm_slv_waitreq) i++;
      guard++;
    end
    if (i < cnt) flag({name, "_timeout"});
    @(posedge clk); #1;
    avmm_slv_write = 1'b0;
    @(negedge clk);
    check({name, "_idle_waitreq"}, 32'(avmm_slv_waitreq), 32'd1);
    check({name, "_beats_left"}, 32'(exp_wr.size()), 32'd0);
    check({name, "_cmds_left"}, 32'(exp_cmd.size()), 32'd0);
  endtask

  task automatic start_read(input logic [FAW-1:0] addr, input int cnt, input string name);
    int waits;
    for (int k = 0; k < cnt; k++) exp_rd.push_back({4'hD, addr + FAW'(4 * k)});
    @(posedge clk); #1;
    avmm_slv_addr     = addr;
    avmm_slv_burstcnt = BW'(cnt);
    avmm_slv_read     = 1'b1;
    waits = 0;
    @(negedge clk);
    while (avmm_slv_waitreq && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    check({name, "_ack_wait_cycles"}, 32'(waits), 32'd1);
    @(posedge clk); #1;
    avmm_slv_read = 1'b0;
  endtask

  task automatic do_read(input logic [FAW-1:0] addr, input int cnt, input string name);
    int seen0;
    int guard;
    seen0 = rd_seen;
    start_read(addr, cnt, name);
    guard = 0;
    while (exp_rd.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_rd.size() != 0) flag({name, "_rd_timeout"});
    repeat (2) @(negedge clk);
    check({name, "_rddvld_count"}, 32'(rd_seen - seen0), 32'(cnt));
    check({name, "_cmds_left"}, 32'(exp_cmd.size()), 32'd0);
    check({name, "_idle_waitreq"}, 32'(avmm_slv_waitreq), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int seen0;
    int guard;
    reset             = 1'b1;
    avmm_slv_addr     = '0;
    avmm_slv_write    = 1'b0;
    avmm_slv_read     = 1'b0;
    avmm_slv_burstcnt = '0;
    avmm_slv_wrdata   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_slv_waitreq", 32'(avmm_slv_waitreq), 32'd1);
    check("rst_mstr_write", 32'(avmm_mstr_write), 32'd0);
    check("rst_mstr_read", 32'(avmm_mstr_read), 32'd0);
    check("rst_slv_rddvld", 32'(avmm_slv_rddvld), 32'd0);
    check("rst_err", 32'(err_zero_burst), 32'd0);
    check("rst_mstr_addr", 32'(avmm_mstr_addr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: aligned full page, single sub-burst at MAX_BURST.
    exp_cmd.push_back(mk_cmd(1'b1, 28'h100, 64));
    do_write(28'h100, 64, 8'h01, "t1");

    // 2: 0x1F0 leaves 4 words in the page, remainder 60 in the next.
    exp_cmd.push_back(mk_cmd(1'b1, 28'h1F0, 4));
    exp_cmd.push_back(mk_cmd(1'b1, 28'h200, 60));
    do_write(28'h1F0, 64, 8'h02, "t2");

    // 3: read straddling a page with one word before the boundary.
    exp_cmd.push_back(mk_cmd(1'b0, 28'h3FC, 1));
    exp_cmd.push_back(mk_cmd(1'b0, 28'h400, 9));
    do_read(28'h3FC, 10, "t3");

    // 4: random downstream backpressure.
    rand_wait = 1'b1;
    exp_cmd.push_back(mk_cmd(1'b1, 28'h0E0, 8));
    exp_cmd.push_back(mk_cmd(1'b1, 28'h100, 25));
    do_write(28'h0E0, 33, 8'h04, "t4");
    exp_cmd.push_back(mk_cmd(1'b0, 28'h1F8, 2));
    exp_cmd.push_back(mk_cmd(1'b0, 28'h200, 1));
    do_read(28'h1F8, 3, "t4r");
    rand_wait = 1'b0;
    repeat (2) @(posedge clk);

    // 5: zero-length command.
    @(posedge clk); #1;
    avmm_slv_addr     = 28'h40;
    avmm_slv_burstcnt = '0;
    avmm_slv_write    = 1'b1;
    @(negedge clk);
    check("t5_err_before", 32'(err_zero_burst), 32'd0);
    check("t5_capture_waitreq", 32'(avmm_slv_waitreq), 32'd1);
    @(negedge clk);
    check("t5_ack_waitreq", 32'(avmm_slv_waitreq), 32'd0);
    check("t5_err_set", 32'(err_zero_burst), 32'd1);
    check("t5_no_mstr_write", 32'(avmm_mstr_write), 32'd0);
    @(posedge clk); #1;
    avmm_slv_write = 1'b0;
    @(negedge clk);
    check("t5_waitreq_back", 32'(avmm_slv_waitreq), 32'd1);
    repeat (3) @(negedge clk);
    check("t5_err_sticky", 32'(err_zero_burst), 32'd1);

    // 6: reset in the middle of read data, then a fresh write.
    exp_cmd.push_back(mk_cmd(1'b0, 28'h100, 40));
    seen0 = rd_seen;
    start_read(28'h100, 40, "t6");
    guard = 0;
    while (rd_seen < seen0 + 5 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (rd_seen < seen0 + 5) flag("t6_rd_start_timeout");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd.delete();
    exp_cmd.delete();
    @(negedge clk);
    check("t6_rst_waitreq", 32'(avmm_slv_waitreq), 32'd1);
    check("t6_rst_mstr_read", 32'(avmm_mstr_read), 32'd0);
    check("t6_rst_mstr_write", 32'(avmm_mstr_write), 32'd0);
    check("t6_rst_rddvld", 32'(avmm_slv_rddvld), 32'd0);
    check("t6_rst_err", 32'(err_zero_burst), 32'd0);
    exp_cmd.push_back(mk_cmd(1'b1, 28'h7F8, 2));
    exp_cmd.push_back(mk_cmd(1'b1, 28'h800, 3));
    do_write(28'h7F8, 5, 8'h06, "t6w");
    repeat (40) @(negedge clk);
    check("t6_no_stray_rd", 32'(exp_rd.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
